matmult_arbiter: RTL and testbench



---
 rtl/matmult_arbiter.sv | 170 +++++++++++++++++
 tb/tb_matmult_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmult_arbiter.sv
// matmult_arbiter: round-robin sharing of one matmult engine among NREQ clients.
// Optional WAIT watchdog and rsp_err port: define MATMULT_ARB_TIMEOUT_EN.
module matmult_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 64,
  parameter int A_N     = 10,
  parameter int B_N     = 10,
  parameter int C_N     = 25,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*A_N*DW-1:0]   req_a,
  input  logic [NREQ*B_N*DW-1:0]   req_b,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [C_N*DW-1:0]        rsp_c,
  output logic                     eng_ready,
  output logic                     eng_accept,
  input  logic                     eng_valid,
  output logic [A_N*DW-1:0]        eng_a,
  output logic [B_N*DW-1:0]        eng_b,
  input  logic [C_N*DW-1:0]        eng_c,
  output logic                     busy,
`ifdef MATMULT_ARB_TIMEOUT_EN
  output logic                     rsp_err,
`endif
  output logic [$clog2(NREQ)-1:0]  grant_id
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [IW-1:0]       grant_q, grant_d;
  logic [A_N*DW-1:0]   a_q, a_d;
  logic [B_N*DW-1:0]   b_q, b_d;
  logic [C_N*DW-1:0]   c_q, c_d;
  logic                win_found;
  logic [IW-1:0]       win_id;

`ifdef MATMULT_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // Round-robin pick: first pending bit at or after rr_q, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_q) + k) % NREQ]) begin
        win_found = 1'b1;
        win_id    = IW'((int'(rr_q) + k) % NREQ);
      end
    end
  end

  // Next-state and handshake outputs of the job sequencer.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    req_ready  = '0;
    eng_ready  = 1'b0;
    eng_accept = 1'b0;
`ifdef MATMULT_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          req_ready[win_id] = rst;
          a_d     = req_a[int'(win_id)*A_N*DW +: A_N*DW];
          b_d     = req_b[int'(win_id)*B_N*DW +: B_N*DW];
          grant_d = win_id;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        eng_ready = 1'b1;
        state_d   = WAIT;
`ifdef MATMULT_ARB_TIMEOUT_EN
        cnt_d     = '0;
        err_d     = 1'b0;
`endif
      end
      WAIT: begin
        if (eng_valid) begin
          eng_accept = 1'b1;
          c_d        = eng_c;
          state_d    = RESP;
        end
`ifdef MATMULT_ARB_TIMEOUT_EN
        else if (cnt_q == TW'(TIMEOUT - 1)) begin
          eng_accept = 1'b1;
          c_d        = '0;
          err_d      = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          rr_d    = (int'(grant_q) == NREQ - 1) ? '0 : grant_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, operand and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

`ifdef MATMULT_ARB_TIMEOUT_EN
  // Watchdog counter and timed-out flag for the job in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rsp_err = (state_q == RESP) && err_q;
`endif

  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP) ? (NREQ'(1) << grant_q) : '0;
  assign rsp_c     = c_q;
  assign eng_a     = a_q;
  assign eng_b     = b_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_matmult_arbiter.sv
// tb_matmult_arbiter: directed bench for matmult_arbiter with a 3-cycle
// behavioural engine that holds eng_valid one stale cycle after accept.
module tb_matmult_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 64;
  localparam int A_N  = 10;
  localparam int B_N  = 10;
  localparam int C_N  = 25;
`ifdef MATMULT_ARB_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 255;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NREQ-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*A_N*DW-1:0] req_a;
  logic [NREQ*B_N*DW-1:0] req_b;
  logic [C_N*DW-1:0]      rsp_c, eng_c;
  logic                   eng_ready, eng_accept, eng_valid, busy;
  logic [A_N*DW-1:0]      eng_a;
  logic [B_N*DW-1:0]      eng_b;
  logic [1:0]             grant_id;
`ifdef MATMULT_ARB_TIMEOUT_EN
  logic                   rsp_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  matmult_arbiter #(
    .NREQ(NREQ), .DW(DW), .A_N(A_N), .B_N(B_N), .C_N(C_N), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
    .eng_ready(eng_ready), .eng_accept(eng_accept), .eng_valid(eng_valid),
    .eng_a(eng_a), .eng_b(eng_b), .eng_c(eng_c),
    .busy(busy),
`ifdef MATMULT_ARB_TIMEOUT_EN
    .rsp_err(rsp_err),
`endif
    .grant_id(grant_id)
  );

  // 5x2 * 2x5 product, row-major element packing
  function automatic logic [C_N*DW-1:0] mm(input logic [A_N*DW-1:0] a,
                                           input logic [B_N*DW-1:0] b);
    logic [C_N*DW-1:0] c;
    logic [DW-1:0] s;
    c = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        s = '0;
        for (int k = 0; k < 2; k++)
          s = s + a[(i*2+k)*DW +: DW] * b[(k*5+j)*DW +: DW];
        c[(i*5+j)*DW +: DW] = s;
      end
    return c;
  endfunction

  logic [1:0] e_d;
  logic       e_stale;
  logic       hang = 1'b0;

  // engine: valid 3 cycles after ready, held one extra cycle after accept
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_valid <= 1'b0;
      e_d       <= 2'd0;
      e_stale   <= 1'b0;
      eng_c     <= '0;
    end else begin
      if (eng_ready && !hang) e_d <= 2'd1;
      else if (e_d == 2'd1) e_d <= 2'd2;
      else if (e_d == 2'd2) begin
        e_d       <= 2'd0;
        eng_valid <= 1'b1;
        eng_c     <= mm(eng_a, eng_b);
      end
      if (eng_valid) begin
        if (eng_accept) e_stale <= 1'b1;
        else if (e_stale) begin
          eng_valid <= 1'b0;
          e_stale   <= 1'b0;
        end
      end
    end
  end

  int n_rdy = 0;
  int n_acc = 0;
  int n_gap = 0;
  int glog[$];

  always @(posedge clk) begin
    if (rst) begin
      if (eng_ready) n_rdy <= n_rdy + 1;
      if (eng_accept) n_acc <= n_acc + 1;
      if (!busy && req_valid != 0 && req_ready == 0) n_gap <= n_gap + 1;
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i]) glog.push_back(i);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ce(input int e);
    return rsp_c[e*DW +: DW];
  endfunction

  function automatic logic [63:0] ea(input int e);
    return eng_a[e*DW +: DW];
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int k;
    int r0;
    int a0;
    int ord[5];
    ord = '{0, 1, 2, 3, 0};
    req_valid = '0;
    rsp_ready = '0;
    req_a = '0;
    req_b = '0;
    for (int e = 0; e < 10; e++) begin
      req_a[e*DW +: DW] = 64'(e + 1);
      req_b[e*DW +: DW] = 64'(e + 1);
    end
    for (int r = 1; r < NREQ; r++)
      for (int e = 0; e < 10; e++) begin
        req_a[(r*A_N+e)*DW +: DW] = 64'(r + 1);
        req_b[(r*B_N+e)*DW +: DW] = 64'd1;
      end

    // reset state, with a request pending
    repeat (2) @(negedge clk);
    req_valid = 4'b0001;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_eng_ready", 64'(eng_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_eng_a", 64'(|eng_a), 64'd0);
    chk("rst_rsp_c", 64'(|rsp_c), 64'd0);

    // single job
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("sj_req_ready", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("sj_req_ready_off", 64'(req_ready), 64'h0);
    chk("sj_eng_ready", 64'(eng_ready), 64'h1);
    chk("sj_busy", 64'(busy), 64'h1);
    chk("sj_a0", ea(0), 64'd1);
    chk("sj_a9", ea(9), 64'd10);
    @(negedge clk);
    chk("sj_eng_ready_1cyc", 64'(eng_ready), 64'h0);
    repeat (2) @(negedge clk);
    chk("sj_accept", 64'(eng_accept), 64'h1);
    @(negedge clk);
    chk("sj_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("sj_c0", ce(0), 64'd13);
    chk("sj_c5", ce(5), 64'd27);
    chk("sj_c24", ce(24), 64'd145);
    chk("sj_stale_no_acc", 64'(eng_accept), 64'h0);
    @(negedge clk);
    chk("sj_rsp_hold", 64'(rsp_valid), 64'h1);
    chk("sj_n_rdy", 64'(n_rdy), 64'd1);
    chk("sj_n_acc", 64'(n_acc), 64'd1);
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = 4'b0000;
    #1;
    chk("sj_idle", 64'(busy), 64'h0);
    chk("sj_rsp_off", 64'(rsp_valid), 64'h0);

    // reset pulse, then contention from rr_ptr=0
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    glog.delete();
    r0 = n_rdy;
    a0 = n_acc;
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    k = 0;
    while (glog.size() < 5 && k < 60) begin
      @(negedge clk);
      k++;
    end
    req_valid = 4'b0000;
    chk("ct_bound", 64'(k < 60), 64'd1);
    for (int i = 0; i < 5; i++)
      chk($sformatf("ct_order%0d", i),
          64'((i < glog.size()) ? glog[i] : 99), 64'(ord[i]));
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ct_drain", 64'(busy), 64'h0);
    chk("ct_n_rdy", 64'(n_rdy - r0), 64'd5);
    chk("ct_n_acc", 64'(n_acc - a0), 64'd5);
    chk("ct_no_gap", 64'(n_gap), 64'd0);
    chk("ct_no_extra", 64'(glog.size()), 64'd5);

    // backpressure on requester 2
    rsp_ready = 4'b0000;
    r0 = n_rdy;
    a0 = n_acc;
    req_valid = 4'b0100;
    k = 0;
    while (rsp_valid == 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk("bp_rsp_valid", 64'(rsp_valid), 64'h4);
    chk("bp_grant", 64'(grant_id), 64'd2);
    chk("bp_c0", ce(0), 64'd6);
    chk("bp_c24", ce(24), 64'd6);
    rsp_ready = 4'b1011;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(rsp_valid), 64'h4);
      chk("bp_hold_c", ce(24), 64'd6);
    end
    chk("bp_n_rdy", 64'(n_rdy - r0), 64'd1);
    chk("bp_n_acc", 64'(n_acc - a0), 64'd1);
    rsp_ready = 4'b0100;
    req_valid = 4'b0000;
    @(negedge clk);
    rsp_ready = 4'b0000;
    #1;
    chk("bp_done", 64'(busy), 64'h0);
    chk("bp_rsp_off", 64'(rsp_valid), 64'h0);

    // async reset during WAIT
    req_valid = 4'b1000;
    k = 0;
    while (!eng_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ar_grant3", 64'(grant_id), 64'd3);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_busy", 64'(busy), 64'h0);
    chk("ar_grant", 64'(grant_id), 64'd0);
    chk("ar_req_ready", 64'(req_ready), 64'h0);
    chk("ar_rsp_c", 64'(|rsp_c), 64'd0);
    chk("ar_eng_a", 64'(|eng_a), 64'd0);
    chk("ar_accept", 64'(eng_accept), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b0010;
    #1;
    chk("ar_rr0", 64'(req_ready), 64'h2);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("ar_grant1", 64'(grant_id), 64'd1);
    k = 0;
    while (rsp_valid == 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ar_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("ar_c0", ce(0), 64'd4);
    rsp_ready = 4'b0010;
    @(negedge clk);
    rsp_ready = 4'b0000;

`ifdef MATMULT_ARB_TIMEOUT_EN
    // engine never answers
    hang = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    k = 0;
    while (!eng_accept && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("to_wait_cycles", 64'(k), 64'd20);
    @(negedge clk);
    chk("to_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("to_rsp_err", 64'(rsp_err), 64'h1);
    chk("to_rsp_c", 64'(|rsp_c), 64'd0);
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = 4'b0000;
    chk("to_err_off", 64'(rsp_err), 64'h0);
    hang = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
